fft8_seq_ctrl: RTL
==================

FFT8_SEQ_CTRL -- requirements
Module: fft8_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, data width 2**N (16) of the butterfly datapath it sequences.
REQ-002 SHALL have parameter BF_LAT, default 1, butterfly read-to-result latency in cycles; legal range 1..4.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer presents one sample this cycle.
REQ-006 in_ready  output  1  controller accepts a sample this cycle.
REQ-007 out_valid  output  1  sample at out_addr is valid in sample RAM.
REQ-008 out_ready  input  1  consumer takes the sample this cycle.
REQ-009 ld_addr  output  3  sample-RAM write address for the accepted input.
REQ-010 addr_a, addr_b  output  3 each  butterfly operand read addresses.
REQ-011 tw_sel  output  2  twiddle index W8^tw_sel for current butterfly.
REQ-012 bf_en  output  1  butterfly read issued this cycle.
REQ-013 wr_en  output  1  write back butterfly results this cycle.
REQ-014 wr_addr_a, wr_addr_b  output  3 each  write-back addresses.
REQ-015 out_addr  output  3  sample-RAM read address for output.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after eighth output handshake.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, STAGE, GAP, DRAIN.
REQ-019 IDLE: in_ready=1; first in_valid&&in_ready moves to LOAD with count 1.
REQ-020 LOAD: in_ready=1; each handshake increments 3-bit count; eighth handshake (count wraps 7->0) moves to STAGE, stage=0, k=0.
REQ-021 in_ready SHALL be 0 in STAGE, GAP, DRAIN; in_valid there is ignored.
REQ-022 STAGE: bf_en=1 every cycle, k=0..3; for stage s, h=1<<s: a=(k>>s)*2h+(k&(h-1)), b=a+h, tw_sel=(k&(h-1))<<(2-s).
REQ-023 wr_en and wr_addr_a/b SHALL be bf_en and addr_a/b delayed exactly BF_LAT cycles via shift pipeline.
REQ-024 After k=3: stage<2 -> GAP; stage=2 -> GAP then DRAIN.
REQ-025 GAP SHALL last exactly BF_LAT cycles, so no read of stage s+1 precedes the final write of stage s; stage increments on GAP exit.
REQ-026 DRAIN: out_valid=1, out_addr=count from 0; advance only on out_valid&&out_ready; out_ready low holds out_addr.
REQ-027 Eighth output handshake SHALL pulse done and return to IDLE; in_ready rises the following cycle.
REQ-028 Per-frame latency with no stalls SHALL be 8 load + 12 butterfly + 3*BF_LAT gap cycles, then first out_valid.
REQ-029 bf_en, wr_en, out_valid SHALL never be high in the same cycle as in_ready.

Reset
REQ-030 rst low SHALL immediately force IDLE, count=0, stage=0, k=0, pipeline cleared; outputs: in_ready=0 while rst low, all addresses 0, tw_sel=0, bf_en=wr_en=out_valid=busy=done=0.
REQ-031 Reset mid-frame SHALL discard the frame; no wr_en asserts after deassertion from pre-reset reads.
REQ-032 in_ready SHALL be 1 on the first clock edge after rst deasserts.

Configuration
REQ-033 Macro FFT8_SEQ_BITREV_EN defined: ld_addr = bit-reverse(count) (0,4,2,6,1,5,3,7); output order natural.
REQ-034 Macro undefined: ld_addr = count; producer supplies bit-reversed order; all else identical.

Structure
REQ-035 Shared package SHALL hold FSM state encoding, 3-bit address type, bit-reverse function, and constants NPTS=8, NSTAGES=3, BF_PER_STAGE=4.
REQ-036 One sub-module, fft8_addr_gen, SHALL compute addr_a/addr_b/tw_sel from stage and k combinationally.

Verification
REQ-037 Reset then 8 back-to-back in_valid -> ld_addr 0,4,2,6,1,5,3,7 (BITREV_EN), in_ready drops after eighth.
REQ-038 Stage trace, BF_LAT=1 -> stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3; wr_en one cycle after each bf_en.
REQ-039 BF_LAT=3 -> each GAP 3 cycles; first out_valid 8+12+9 cycles after first load handshake.
REQ-040 out_ready toggled 1,0,0,1... in DRAIN -> out_addr holds on 0 cycles, 8 handshakes, single done pulse, then IDLE.
REQ-041 rst asserted during stage 1, k=2 -> all outputs 0 asynchronously; no wr_en after release; fresh frame processes correctly.
REQ-042 in_valid held high through STAGE/DRAIN -> no extra ld_addr activity, in_ready stays 0 until IDLE.

Source files
------------

// File: rtl/fft8_seq_pkg.sv
// fft8_seq_pkg: shared types, constants and helpers for the 8-point FFT sequencer
//   state_t : controller FSM encoding
//   addr_t  : 3-bit sample-RAM address
//   bitrev  : 3-bit bit-reverse used for bit-reversed load order
package fft8_seq_pkg;
  localparam int NPTS = 8;
  localparam int NSTAGES = 3;
  localparam int BF_PER_STAGE = 4;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STAGE, S_GAP, S_DRAIN} state_t;
  typedef logic [2:0] addr_t;
  function automatic addr_t bitrev(input addr_t a);
    return {a[0], a[1], a[2]};
  endfunction
endpackage

// File: rtl/fft8_addr_gen.sv
// fft8_addr_gen: radix-2 butterfly operand addresses and twiddle index from stage and k
//   i_stage : butterfly stage 0..2
//   i_k     : butterfly index within the stage 0..3
//   o_addr_a, o_addr_b : operand addresses (b = a + 2^stage)
//   o_tw_sel           : twiddle exponent of W8
module fft8_addr_gen
  import fft8_seq_pkg::*;
(
  input  logic [1:0] i_stage,
  input  logic [1:0] i_k,
  output addr_t      o_addr_a,
  output addr_t      o_addr_b,
  output logic [1:0] o_tw_sel
);
  always_comb begin
    o_addr_a = i_stage == 2'd0 ? {i_k, 1'b0} :
               i_stage == 2'd1 ? {i_k[1], 1'b0, i_k[0]} : {1'b0, i_k};
    // bit 'stage' of addr_a is always clear, so OR is the same as adding the span
    o_addr_b = o_addr_a | (3'd1 << i_stage);
    o_tw_sel = i_stage == 2'd0 ? 2'd0 :
               i_stage == 2'd1 ? {i_k[0], 1'b0} : i_k;
  end
endmodule

// File: rtl/fft8_seq_ctrl.sv
// fft8_seq_ctrl: load / 3-stage butterfly / drain sequencer for an in-place 8-point FFT
//   clk, rst (async active-low)
//   in_valid/in_ready, ld_addr          : sample load handshake and RAM write address
//   addr_a/addr_b, tw_sel, bf_en        : butterfly read issue
//   wr_en, wr_addr_a/wr_addr_b          : butterfly write-back, BF_LAT cycles after read
//   out_valid/out_ready, out_addr       : result drain handshake and RAM read address
//   busy, done                          : not-idle flag, end-of-frame pulse
//   Macro FFT8_SEQ_BITREV_EN: load addresses in bit-reversed order (else natural).
module fft8_seq_ctrl
  import fft8_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int BF_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output addr_t      ld_addr,
  output addr_t      addr_a,
  output addr_t      addr_b,
  output logic [1:0] tw_sel,
  output logic       bf_en,
  output logic       wr_en,
  output addr_t      wr_addr_a,
  output addr_t      wr_addr_b,
  output addr_t      out_addr,
  output logic       busy,
  output logic       done
);
  if (BF_LAT < 1 || BF_LAT > 4 || N < 1) begin : g_bad_param
    $error("fft8_seq_ctrl: BF_LAT must be 1..4 and N >= 1");
  end
  localparam logic [1:0] GAP_LAST = 2'(BF_LAT - 1);
  state_t r_state, w_next;
  addr_t r_count;
  logic [1:0] r_stage, r_k, r_gap, w_tw;
  logic r_done, w_in_hs, w_out_hs;
  addr_t w_a, w_b;
  logic [BF_LAT-1:0] r_en;
  logic [BF_LAT-1:0][2:0] r_pa, r_pb;
  fft8_addr_gen u_addr_gen (
    .i_stage (r_stage),
    .i_k     (r_k),
    .o_addr_a(w_a),
    .o_addr_b(w_b),
    .o_tw_sel(w_tw)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_hs) w_next = S_LOAD;
      S_LOAD:  if (w_in_hs && r_count == addr_t'(NPTS - 1)) w_next = S_STAGE;
      S_STAGE: if (r_k == 2'(BF_PER_STAGE - 1)) w_next = S_GAP;
      S_GAP:   if (r_gap == GAP_LAST) w_next = r_stage == 2'(NSTAGES - 1) ? S_DRAIN : S_STAGE;
      S_DRAIN: if (w_out_hs && r_count == addr_t'(NPTS - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // in_ready is gated by rst so it stays low while reset is held even though the state reads IDLE
  always_comb begin
    in_ready  = rst && (r_state == S_IDLE || r_state == S_LOAD);
    bf_en     = r_state == S_STAGE;
    out_valid = r_state == S_DRAIN;
    busy      = r_state != S_IDLE;
    done      = r_done;
    w_in_hs   = in_valid && in_ready;
    w_out_hs  = out_valid && out_ready;
`ifdef FFT8_SEQ_BITREV_EN
    ld_addr   = in_ready ? bitrev(r_count) : 3'd0;
`else
    ld_addr   = in_ready ? r_count : 3'd0;
`endif
    addr_a    = bf_en ? w_a : 3'd0;
    addr_b    = bf_en ? w_b : 3'd0;
    tw_sel    = bf_en ? w_tw : 2'd0;
    out_addr  = out_valid ? r_count : 3'd0;
    wr_en     = r_en[BF_LAT-1];
    wr_addr_a = r_pa[BF_LAT-1];
    wr_addr_b = r_pb[BF_LAT-1];
  end
  // one counter serves both load and drain; it wraps to 0 at the end of each
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_count, r_stage, r_k, r_gap, r_done} <= '0;
      r_en <= '0;
      r_pa <= '0;
      r_pb <= '0;
    end else begin
      r_done <= w_out_hs && r_count == addr_t'(NPTS - 1);
      if (w_in_hs || w_out_hs) r_count <= r_count + 3'd1;
      r_k <= bf_en ? r_k + 2'd1 : 2'd0;
      r_gap <= r_state == S_GAP ? r_gap + 2'd1 : 2'd0;
      if (r_state == S_GAP && r_gap == GAP_LAST)
        r_stage <= r_stage == 2'(NSTAGES - 1) ? 2'd0 : r_stage + 2'd1;
      r_en[0] <= bf_en;
      r_pa[0] <= addr_a;
      r_pb[0] <= addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_en[i] <= r_en[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end
endmodule
